// File: rtl/bf_engine.sv
// bf_engine: single-clock Brainfuck interpreter between a sync program ROM, a single-port data RAM and ./, streams.
// Latency: one instruction per FETCH+EXEC pair, paced by a DIV-clock tick (2 clocks minimum); I/O adds handshake wait.
// Backpressure: OUT holds out_valid/out_data until out_ready; IN holds in_ready until in_valid; nothing is dropped.
module bf_engine #(
    parameter int CELL_W  = 8,
    parameter int DADDR_W = 8,
    parameter int PADDR_W = 10,
    parameter int STACK_D = 16,
    parameter int DIV     = 100
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               run,
    output logic [PADDR_W-1:0] prog_addr,
    input  logic [2:0]         prog_code,
    input  logic               prog_end,
    output logic [DADDR_W-1:0] ram_addr,
    input  logic [CELL_W-1:0]  ram_rdata,
    output logic               ram_we,
    output logic [CELL_W-1:0]  ram_wdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CELL_W-1:0]  out_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CELL_W-1:0]  in_data,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code
);
    localparam int SP_W  = $clog2(STACK_D) + 1;           // holds 0..STACK_D
    localparam int SI_W  = SP_W - 1;                      // stack entry index
    localparam int SD_W  = $clog2((1 << PADDR_W) + 1);    // skip depth can never exceed program size
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [2:0] OP_INC   = 3'd0;
    localparam logic [2:0] OP_DEC   = 3'd1;
    localparam logic [2:0] OP_RIGHT = 3'd2;
    localparam logic [2:0] OP_LEFT  = 3'd3;
    localparam logic [2:0] OP_LOOP  = 3'd4;
    localparam logic [2:0] OP_BACK  = 3'd5;
    localparam logic [2:0] OP_OUT   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_OUT, S_IN, S_DONE, S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [PADDR_W-1:0]  pc_q, pc_d;
    logic [DADDR_W-1:0]  dp_q, dp_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [SD_W-1:0]     skip_q, skip_d;
    logic [1:0]          err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CELL_W-1:0]   odat_q, odat_d;

    logic [PADDR_W-1:0]  stack_mem [STACK_D];
    logic                push_en;
    logic                tick;
    logic                cell_nz;
    logic                stack_full;
    logic [SI_W-1:0]     top_idx;
    logic [PADDR_W-1:0]  top_pc;
    logic [PADDR_W-1:0]  pc_inc;

    assign tick       = (cnt_q == CNT_W'(DIV - 1));
    assign cell_nz    = (ram_rdata != '0);
    assign stack_full = (sp_q == SP_W'(STACK_D));
    assign top_idx    = sp_q[SI_W-1:0] - SI_W'(1);
    assign top_pc     = stack_mem[top_idx];
    assign pc_inc     = pc_q + PADDR_W'(1);

    // The ROM and RAM register these addresses, so opcode and cell arrive during EXEC.
    assign prog_addr = pc_q;
    assign ram_addr  = dp_q;
    assign out_data  = odat_q;
    assign out_valid = (state_q == S_OUT);
    assign in_ready  = (state_q == S_IN);
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);
    assign err_code  = err_q;

    // Free-running instruction pacing counter, parked at zero while idle.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_q == S_IDLE || tick) begin
            cnt_d = '0;
        end
    end

    // Next-state and datapath decode; a '[' with a zero cell enters skip mode and counts brackets only.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        dp_d      = dp_q;
        sp_d      = sp_q;
        skip_d    = skip_q;
        err_d     = err_q;
        odat_d    = odat_q;
        ram_we    = 1'b0;
        ram_wdata = '0;
        push_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    dp_d    = '0;
                    sp_d    = '0;
                    skip_d  = '0;
                    err_d   = 2'd0;
                end
            end
            S_FETCH: begin
                if (tick) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (skip_q != '0) begin
                    if (prog_end) begin
                        state_d = S_ERROR;
                        err_d   = 2'd3;
                    end else begin
                        pc_d = pc_inc;
                        if (prog_code == OP_LOOP) begin
                            skip_d = skip_q + SD_W'(1);
                        end else if (prog_code == OP_BACK) begin
                            skip_d = skip_q - SD_W'(1);
                        end
                    end
                end else if (prog_end) begin
                    state_d = S_DONE;
                end else begin
                    pc_d = pc_inc;
                    case (prog_code)
                        OP_INC: begin
                            ram_we    = 1'b1;
                            ram_wdata = ram_rdata + CELL_W'(1);
                        end
                        OP_DEC: begin
                            ram_we    = 1'b1;
                            ram_wdata = ram_rdata - CELL_W'(1);
                        end
                        OP_RIGHT: dp_d = dp_q + DADDR_W'(1);
                        OP_LEFT:  dp_d = dp_q - DADDR_W'(1);
                        OP_LOOP: begin
                            if (!cell_nz) begin
                                skip_d = SD_W'(1);
                            end else if (stack_full) begin
                                state_d = S_ERROR;
                                err_d   = 2'd1;
                                pc_d    = pc_q;
                            end else begin
                                push_en = 1'b1;
                                sp_d    = sp_q + SP_W'(1);
                            end
                        end
                        OP_BACK: begin
                            if (sp_q == '0) begin
                                state_d = S_ERROR;
                                err_d   = 2'd2;
                                pc_d    = pc_q;
                            end else if (cell_nz) begin
                                // Jump to the body start; the matching '[' stays on the stack.
                                pc_d = top_pc + PADDR_W'(1);
                            end else begin
                                sp_d = sp_q - SP_W'(1);
                            end
                        end
                        OP_OUT: begin
                            pc_d    = pc_q;
                            odat_d  = ram_rdata;
                            state_d = S_OUT;
                        end
                        default: begin
                            pc_d    = pc_q;
                            state_d = S_IN;
                        end
                    endcase
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_IN: begin
                if (in_valid) begin
                    ram_we    = 1'b1;
                    ram_wdata = in_data;
                    pc_d      = pc_inc;
                    state_d   = S_FETCH;
                end
            end
            S_DONE, S_ERROR: begin
                if (!run) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            dp_q    <= '0;
            sp_q    <= '0;
            skip_q  <= '0;
            err_q   <= 2'd0;
            cnt_q   <= '0;
            odat_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            dp_q    <= dp_d;
            sp_q    <= sp_d;
            skip_q  <= skip_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            odat_q  <= odat_d;
        end
    end

    // Bracket return-address storage; entries above sp are never read, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[sp_q[SI_W-1:0]] <= pc_q;
        end
    end
endmodule

// File: tb/tb_bf_engine.sv
// tb_bf_engine: drives bf_engine with directed and random Brainfuck programs against an interpreter model.
// Latency: checks FETCH/EXEC clock counts at DIV=1 and tick spacing at DIV=100.
// Backpressure: randomly stalls out_ready and in_valid, plus fixed-length holds.
module tb_bf_engine;
    localparam int STACK_D  = 2;
    localparam int STEP_MAX = 200;
    localparam int NIN      = 512;

    logic       clk;
    logic       nrst;
    logic       run;
    logic [7:0] prog_addr;
    logic [2:0] prog_code;
    logic       prog_end;
    logic [7:0] ram_addr;
    logic [7:0] ram_rdata;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    logic       run2;
    logic [7:0] prog_addr2;
    logic [2:0] prog_code2;
    logic       prog_end2;
    logic [7:0] ram_addr2;
    logic [7:0] ram_rdata2;
    logic       ram_we2;
    logic [7:0] ram_wdata2;
    logic       out_valid2;
    logic [7:0] out_data2;
    logic       in_ready2;
    logic       busy2;
    logic       done2;
    logic       error2;
    logic [1:0] err_code2;

    int n_tests = 0;
    int n_fail  = 0;

    byte        prog_b [256];
    int         prog_len = 0;
    logic [7:0] ram      [256];
    logic [7:0] ram_init [256];
    logic [7:0] ram2     [256];
    logic [7:0] in_vals  [NIN];
    logic       load_req;
    int         wr_cnt   = 0;
    int         cyc_cnt  = 0;
    int         we2_cyc [$];
    int         in_idx;

    logic [7:0] m_ram [256];
    logic [7:0] m_out [$];
    int         m_status;   // 1 done, 2 error
    int         m_err;
    int         m_writes;
    int         m_steps;
    bit         m_ok;

    logic [7:0] got_out [$];
    int         r_busy;
    int         r_first_beat;
    int         r_writes;

    bf_engine #(.CELL_W(8), .DADDR_W(8), .PADDR_W(8), .STACK_D(STACK_D), .DIV(1)) u_dut (
        .clk(clk), .nrst(nrst), .run(run),
        .prog_addr(prog_addr), .prog_code(prog_code), .prog_end(prog_end),
        .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    bf_engine #(.CELL_W(8), .DADDR_W(8), .PADDR_W(8), .STACK_D(16), .DIV(100)) u_slow (
        .clk(clk), .nrst(nrst), .run(run2),
        .prog_addr(prog_addr2), .prog_code(prog_code2), .prog_end(prog_end2),
        .ram_addr(ram_addr2), .ram_rdata(ram_rdata2), .ram_we(ram_we2), .ram_wdata(ram_wdata2),
        .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2),
        .in_valid(1'b0), .in_ready(in_ready2), .in_data(8'h00),
        .busy(busy2), .done(done2), .error(error2), .err_code(err_code2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] op_of(input byte c);
        case (c)
            "+":     return 3'd0;
            "-":     return 3'd1;
            ">":     return 3'd2;
            "<":     return 3'd3;
            "[":     return 3'd4;
            "]":     return 3'd5;
            ".":     return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    // Synchronous ROM/RAM models for both engines; the slow engine always runs "+++".
    always @(posedge clk) begin
        cyc_cnt    <= cyc_cnt + 1;
        prog_code  <= op_of(prog_b[prog_addr]);
        prog_end   <= (int'(prog_addr) >= prog_len);
        ram_rdata  <= ram[ram_addr];
        prog_code2 <= 3'd0;
        prog_end2  <= (prog_addr2 >= 8'd3);
        ram_rdata2 <= ram2[ram_addr2];
        if (load_req) begin
            for (int i = 0; i < 256; i++) begin
                ram[i]  <= ram_init[i];
                ram2[i] <= 8'h00;
            end
        end else begin
            if (ram_we) begin
                ram[ram_addr] <= ram_wdata;
                wr_cnt        <= wr_cnt + 1;
            end
            if (ram_we2) begin
                ram2[ram_addr2] <= ram_wdata2;
                we2_cyc.push_back(cyc_cnt);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_prog(input string s);
        for (int i = 0; i < s.len(); i++) prog_b[i] = s[i];
        prog_len = s.len();
    endtask

    task automatic clear_init();
        for (int i = 0; i < 256; i++) ram_init[i] = 8'h00;
    endtask

    task automatic load_ram();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Reference interpreter: loops resolved by bracket scanning and a return-address queue.
    task automatic model_run();
        int pc = 0;
        int dp = 0;
        int nin = 0;
        int st [$];
        for (int i = 0; i < 256; i++) m_ram[i] = ram_init[i];
        m_out.delete();
        m_writes = 0;
        m_steps  = 0;
        m_err    = 0;
        m_status = 0;
        m_ok     = 1'b1;
        while (m_status == 0) begin
            if (m_steps > STEP_MAX) begin
                m_ok = 1'b0;
                return;
            end
            m_steps++;
            if (pc >= prog_len) begin
                m_status = 1;
            end else begin
                case (prog_b[pc])
                    "+": begin m_ram[dp] = m_ram[dp] + 8'd1; m_writes++; pc++; end
                    "-": begin m_ram[dp] = m_ram[dp] - 8'd1; m_writes++; pc++; end
                    ">": begin dp = (dp + 1) % 256; pc++; end
                    "<": begin dp = (dp + 255) % 256; pc++; end
                    "[": begin
                        if (m_ram[dp] != 0) begin
                            if (st.size() == STACK_D) begin
                                m_status = 2; m_err = 1;
                            end else begin
                                st.push_back(pc); pc++;
                            end
                        end else begin
                            int depth = 1;
                            int j = pc + 1;
                            while (depth > 0 && m_status == 0) begin
                                if (j >= prog_len) begin
                                    m_status = 2; m_err = 3;
                                end else begin
                                    if (prog_b[j] == "[") depth++;
                                    else if (prog_b[j] == "]") depth--;
                                    j++;
                                end
                            end
                            m_steps += j - pc;
                            pc = j;
                        end
                    end
                    "]": begin
                        if (st.size() == 0) begin
                            m_status = 2; m_err = 2;
                        end else if (m_ram[dp] != 0) begin
                            pc = st[st.size()-1] + 1;
                        end else begin
                            void'(st.pop_back()); pc++;
                        end
                    end
                    ".": begin m_out.push_back(m_ram[dp]); pc++; end
                    default: begin
                        if (nin >= NIN) begin
                            m_ok = 1'b0;
                            return;
                        end
                        m_ram[dp] = in_vals[nin]; nin++; m_writes++; pc++;
                    end
                endcase
            end
        end
    endtask

    // Runs the current program on the DIV=1 engine and compares against the model.
    task automatic run_prog(input int rnd, input int out_stall, input int in_wait);
        int budget;
        int stall_left = out_stall;
        int stall_cnt  = 0;
        int wait_left  = in_wait;
        int wr0;
        int bad = 0;
        bit finished = 1'b0;
        logic [7:0] snap_d;
        logic [7:0] snap_pc;
        logic [7:0] g;
        load_ram();
        model_run();
        budget = 8 * m_steps + 60;
        got_out.delete();
        r_busy = 0;
        r_first_beat = -1;
        in_idx = 0;
        wr0 = wr_cnt;
        run = 1'b1;
        for (int c = 0; c < budget && !finished; c++) begin
            @(negedge clk);
            if (done || error) begin
                finished = 1'b1;
            end else begin
                if (out_valid && stall_left > 0) begin
                    if (stall_cnt == 0) begin
                        snap_d  = out_data;
                        snap_pc = prog_addr;
                    end else begin
                        check("stall_valid", out_valid, 1);
                        check("stall_data", out_data, snap_d);
                        check("stall_pc", prog_addr, snap_pc);
                    end
                    stall_cnt++;
                    stall_left--;
                    out_ready = 1'b0;
                end else begin
                    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (in_ready && wait_left > 0) begin
                    wait_left--;
                    in_valid = 1'b0;
                end else begin
                    in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                in_data = in_vals[in_idx % NIN];
                #1;
                if (busy) r_busy++;
                if (out_valid && out_ready) begin
                    got_out.push_back(out_data);
                    if (r_first_beat < 0) r_first_beat = r_busy;
                end
                if (in_valid && in_ready) in_idx++;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (!finished) check("timeout", 0, 1);
        r_writes = wr_cnt - wr0;
        check("done", done, (m_status == 1));
        check("error", error, (m_status == 2));
        check("err_code", err_code, m_err);
        check("beats", got_out.size(), m_out.size());
        for (int i = 0; i < m_out.size(); i++) begin
            g = (i < got_out.size()) ? got_out[i] : 8'hxx;
            check("beat", g, m_out[i]);
        end
        check("writes", r_writes, m_writes);
        for (int i = 0; i < 256; i++) if (ram[i] !== m_ram[i]) bad++;
        check("ram_bad_cells", bad, 0);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("back_idle", {busy, done, error}, 3'b000);
    endtask

    byte op_tbl [12] = '{"+", "+", "-", "-", ">", "<", "[", "[", "]", "]", ".", ","};

    initial begin
        int n0;
        int wr0;
        int tries;
        int gap1;
        int gap2;
        int first;
        nrst = 1'b0; run = 1'b0; run2 = 1'b0; load_req = 1'b0;
        out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        for (int i = 0; i < NIN; i++) in_vals[i] = 8'($urandom);
        clear_init();
        repeat (3) @(negedge clk);
        check("rst_status", {busy, done, error, err_code}, 5'b0);
        check("rst_stream", {out_valid, in_ready, ram_we}, 3'b0);
        check("rst_addr", {prog_addr, ram_addr}, 16'h0);
        check("rst_data", {out_data, ram_wdata}, 16'h0);
        nrst = 1'b1;

        set_prog("+++."); clear_init();
        run_prog(0, 0, 0);
        check("p1_beat", got_out.size() > 0 ? got_out[0] : 8'hxx, 8'd3);
        check("p1_beat_clk", r_first_beat, 9);
        check("p1_busy_clks", r_busy, 11);

        set_prog("-<+"); clear_init();
        run_prog(0, 0, 0);
        check("wrap_cell", ram[0], 8'hFF);
        check("wrap_ptr", ram[255], 8'h01);

        set_prog("++[>+<-]>."); clear_init();
        run_prog(0, 5, 0);
        check("loop_beat", got_out.size() > 0 ? got_out[0] : 8'hxx, 8'd2);

        set_prog("[[+]+]"); clear_init();
        run_prog(0, 0, 0);
        check("skip_nowrite", r_writes, 0);
        check("skip_busy_clks", r_busy, 14);

        set_prog("+[[["); clear_init();
        run_prog(0, 0, 0);
        check("err_overflow", err_code, 2'd1);
        set_prog("+]"); clear_init();
        run_prog(0, 0, 0);
        check("err_unmatched", err_code, 2'd2);
        set_prog("["); clear_init();
        run_prog(0, 0, 0);
        check("err_skip_end", err_code, 2'd3);

        in_vals[0] = 8'h5A;
        set_prog(",."); clear_init();
        run_prog(0, 0, 4);
        check("in_ram", ram[0], 8'h5A);
        check("in_echo", got_out.size() > 0 ? got_out[0] : 8'hxx, 8'h5A);

        for (int t = 0; t < 40; t++) begin
            tries = 0;
            do begin
                prog_len = $urandom_range(3, 20);
                for (int i = 0; i < prog_len; i++) prog_b[i] = op_tbl[$urandom_range(0, 11)];
                for (int i = 0; i < 256; i++) ram_init[i] = 8'($urandom_range(0, 3));
                model_run();
                tries++;
            end while (!m_ok && tries < 100);
            if (m_ok) run_prog(1, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // DIV=100 engine: "+++" writes exactly once per 100 clocks.
        load_ram();
        n0 = cyc_cnt;
        run2 = 1'b1;
        for (int c = 0; c < 1000 && !done2; c++) @(negedge clk);
        check("slow_done", done2, 1);
        check("slow_ram", ram2[0], 8'd3);
        check("slow_writes", we2_cyc.size(), 3);
        first = (we2_cyc.size() > 0) ? we2_cyc[0] - n0 : -1;
        gap1  = (we2_cyc.size() > 1) ? we2_cyc[1] - we2_cyc[0] : -1;
        gap2  = (we2_cyc.size() > 2) ? we2_cyc[2] - we2_cyc[1] : -1;
        check("slow_first", first, 101);
        check("slow_gap1", gap1, 100);
        check("slow_gap2", gap2, 100);
        run2 = 1'b0;

        // Asynchronous reset while waiting on ','.
        set_prog(","); clear_init();
        load_ram();
        in_valid = 1'b0;
        run = 1'b1;
        for (int c = 0; c < 20 && !in_ready; c++) @(negedge clk);
        check("rst_in_wait", in_ready, 1);
        wr0 = wr_cnt;
        #2;
        nrst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_in_busy", busy, 0);
        run = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_no_write", wr_cnt - wr0, 0);
        check("rst_ram", ram[0], 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
